// File: rtl/spi_tx_pkg.sv
// Shared types and widths for the 8-bit SPI transmitter.
package spi_tx_pkg;

    localparam int BIT_CNT_W = 3;
    localparam int DIV_CNT_W = 8;
    localparam int SEQ_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

endpackage

// File: rtl/spi_tx_8b_if.sv
// Host handshake plus SPI pins of spi_tx_8b; sdo/rdata exist only with SPI_TX_READBACK_EN.
interface spi_tx_8b_if;

    logic       start;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       sclk;
    logic       sdi;
    logic       csb;
`ifdef SPI_TX_READBACK_EN
    logic       sdo;
    logic [7:0] rdata;

    modport master (output start, wdata, sdo, input busy, done, sclk, sdi, csb, rdata);
    modport slave  (input start, wdata, sdo, output busy, done, sclk, sdi, csb, rdata);
`else
    modport master (output start, wdata, input busy, done, sclk, sdi, csb);
    modport slave  (input start, wdata, output busy, done, sclk, sdi, csb);
`endif

endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick fires on the CLK_DIV-th enabled cycle, restarting on disable.
module spi_clk_div
    import spi_tx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [DIV_CNT_W-1:0] LAST = DIV_CNT_W'(CLK_DIV - 1);

    logic [DIV_CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // NOTE: sequential state uses <= so every flop samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_tx_8b.sv
// 8-bit SPI write master (mode 0, MSB first) with csb setup/hold framing.
// Optional SPI_TX_READBACK_EN adds sdo capture into rdata.
module spi_tx_8b
    import spi_tx_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int CSB_SETUP = 2,
    parameter int CSB_HOLD  = 2
) (
    input logic        clk,
    input logic        rst,
    spi_tx_8b_if.slave bus
);

    localparam logic [SEQ_CNT_W-1:0] SETUP_LAST = SEQ_CNT_W'(CSB_SETUP - 1);
    localparam logic [SEQ_CNT_W-1:0] HOLD_LAST  = SEQ_CNT_W'(CSB_HOLD - 1);

    state_t               state;
    state_t               state_nxt;
    logic [SEQ_CNT_W-1:0] seq_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 phase_hi;
    logic [7:0]           tx_sr;
    logic                 done_q;
    logic                 tick;
    logic                 sclk_rise;
    logic                 sclk_fall;
    logic                 frame_end;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .en   (state == SHIFT),
        .tick (tick)
    );

    assign sclk_rise = tick && !phase_hi;
    assign sclk_fall = tick && phase_hi;
    assign frame_end = (state == HOLD) && (state_nxt == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no branch leaves state_nxt unassigned (avoids a latch).
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)                          state_nxt = SETUP;
            SETUP:   if (seq_cnt == SETUP_LAST)              state_nxt = SHIFT;
            SHIFT:   if (sclk_fall && bit_cnt == '1)         state_nxt = HOLD;
            HOLD:    if (seq_cnt == HOLD_LAST)               state_nxt = IDLE;
            default:                                         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.csb  = (state == IDLE);
        bus.sclk = (state == SHIFT) && phase_hi;
        bus.sdi  = (state != IDLE) && tx_sr[7];
        bus.done = done_q;
    end

    // Bit counter advances on each falling edge, so it wraps 7->0 only as the frame ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_cnt  <= '0;
            bit_cnt  <= '0;
            phase_hi <= 1'b0;
            tx_sr    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= frame_end;

            if ((state_nxt != state) || (state == IDLE) || (state == SHIFT)) begin
                seq_cnt <= '0;
            end else begin
                seq_cnt <= seq_cnt + SEQ_CNT_W'(1);
            end

            if (state != SHIFT) begin
                phase_hi <= 1'b0;
            end else if (tick) begin
                phase_hi <= !phase_hi;
            end

            if (sclk_fall) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end

            if (state == IDLE && bus.start) begin
                tx_sr <= bus.wdata;
            end else if (sclk_fall) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
        end
    end

`ifdef SPI_TX_READBACK_EN
    logic [7:0] rx_sr;
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sr   <= '0;
            rdata_q <= '0;
        end else begin
            if (sclk_rise) begin
                rx_sr <= {rx_sr[6:0], bus.sdo};
            end
            if (frame_end) begin
                rdata_q <= rx_sr;
            end
        end
    end

    assign bus.rdata = rdata_q;
`else
    logic unused_rise;
    assign unused_rise = sclk_rise;
`endif

endmodule

// File: tb/tb_spi_tx_8b.sv
// Self-checking bench for spi_tx_8b: table vectors, random frames and multi-cycle corner sequences.
module tb_spi_tx_8b;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] rd_model = 8'h00;

    always #5 clk = ~clk;

    spi_tx_8b_if ifa ();
    spi_tx_8b_if ifb ();

    spi_tx_8b u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    spi_tx_8b #(.CLK_DIV(1), .CSB_SETUP(1), .CSB_HOLD(1)) u_fast (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    typedef struct {
        logic [7:0] wdata;
        logic [7:0] sdo_pat;
        int         exp_busy;
        logic [7:0] exp_byte;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected wire values at offset k after acceptance, from setup/shift timing rules.
    function automatic logic exp_sclk(int k, int d, int s);
        int j;
        if (k < s) return 1'b0;
        j = k - s;
        if (j >= 16 * d) return 1'b0;
        return (j % (2 * d)) >= d;
    endfunction

    function automatic logic exp_bit(int k, logic [7:0] v, int d, int s);
        int b;
        logic [7:0] tmp;
        tmp = v;
        if (k < s) return tmp[7];
        b = (k - s) / (2 * d);
        if (b > 7) b = 7;
        return tmp[7 - b];
    endfunction

    task automatic send_frame_a(input logic [7:0] d, input logic [7:0] pat,
                                input int exp_busy, input logic [7:0] exp_byte,
                                input int repulse_at);
        logic [7:0] cap;
        logic       prev_sclk;
        int         rises;
        int         busy_n;
        int         dones;
        int         k;
        cap = 8'h00; prev_sclk = 1'b0; rises = 0; busy_n = 0; dones = 0; k = 0;
        ifa.start = 1'b1;
        ifa.wdata = d;
`ifdef SPI_TX_READBACK_EN
        ifa.sdo = pat[7];
`endif
        @(negedge clk);
        ifa.start = 1'b0;
        ifa.wdata = 8'($urandom);
        while (ifa.busy && k < 1000) begin
            busy_n++;
            if (ifa.done) dones++;
            check("csb_low", ifa.csb, 1'b0);
            check("sclk_wave", ifa.sclk, exp_sclk(k, 4, 2));
            if (k < 66) check("sdi_wave", ifa.sdi, exp_bit(k, d, 4, 2));
`ifdef SPI_TX_READBACK_EN
            if (k == 0) check("rdata_hold", ifa.rdata, rd_model);
            ifa.sdo = exp_bit(k, pat, 4, 2);
`endif
            if (!prev_sclk && ifa.sclk) begin
                cap = {cap[6:0], ifa.sdi};
                rises++;
            end
            prev_sclk = ifa.sclk;
            ifa.start = (k == repulse_at);
            if (k == repulse_at) ifa.wdata = ~d;
            @(negedge clk);
            k++;
        end
        ifa.start = 1'b0;
        check("frame_end", ifa.busy, 1'b0);
        check("busy_cycles", busy_n, exp_busy);
        check("done_in_frame", dones, 0);
        check("done_pulse", ifa.done, 1'b1);
        check("csb_idle", ifa.csb, 1'b1);
        check("sclk_idle", ifa.sclk, 1'b0);
        check("sdi_idle", ifa.sdi, 1'b0);
        check("rise_count", rises, 8);
        check("rx_byte", cap, exp_byte);
`ifdef SPI_TX_READBACK_EN
        check("rdata", ifa.rdata, pat);
        rd_model = pat;
`endif
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_busy"}, ifa.busy, 1'b0);
        check({tag, "_done"}, ifa.done, 1'b0);
        check({tag, "_csb"}, ifa.csb, 1'b1);
        check({tag, "_sclk"}, ifa.sclk, 1'b0);
        check({tag, "_sdi"}, ifa.sdi, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [5];
        logic [7:0] cap;
        logic [7:0] got [2];
        logic       prev_sclk;
        int         frames;
        int         csb_hi;
        int         n;
        int         busy_n;
        int         rises;
        int         ones;
        int         dones;
        logic [7:0] d;
        logic [7:0] p;

        vecs[0] = '{8'hA5, 8'h3C, 68, 8'hA5};
        vecs[1] = '{8'h00, 8'hFF, 68, 8'h00};
        vecs[2] = '{8'hFF, 8'h00, 68, 8'hFF};
        vecs[3] = '{8'h01, 8'h80, 68, 8'h01};
        vecs[4] = '{8'h80, 8'h01, 68, 8'h80};

        ifa.start = 1'b0; ifa.wdata = 8'h00;
        ifb.start = 1'b0; ifb.wdata = 8'h00;
`ifdef SPI_TX_READBACK_EN
        ifa.sdo = 1'b0; ifb.sdo = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_idle_a("rst");
        check("rst_fast_csb", ifb.csb, 1'b1);
`ifdef SPI_TX_READBACK_EN
        check("rst_rdata", ifa.rdata, 8'h00);
`endif
        rst = 1'b0;
        @(negedge clk);
        check_idle_a("idle");

        for (int i = 0; i < 5; i++) begin
            send_frame_a(vecs[i].wdata, vecs[i].sdo_pat, vecs[i].exp_busy, vecs[i].exp_byte, -1);
            @(negedge clk);
            check("done_drop", ifa.done, 1'b0);
        end

        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            p = 8'($urandom);
            send_frame_a(d, p, 68, d, -1);
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                check("rand_gap_busy", ifa.busy, 1'b0);
            end
        end

        // start re-pulsed mid-frame: ignored and not queued
        send_frame_a(8'h5A, 8'hC3, 68, 8'h5A, 10);
        repeat (5) begin
            @(negedge clk);
            check("no_queue_busy", ifa.busy, 1'b0);
            check("no_queue_done", ifa.done, 1'b0);
        end

        // back-to-back frames with start held high
        ifa.start = 1'b1;
        ifa.wdata = 8'h01;
`ifdef SPI_TX_READBACK_EN
        ifa.sdo = 1'b0;
`endif
        @(negedge clk);
        frames = 0; csb_hi = 0; cap = 8'h00; prev_sclk = 1'b0; n = 0;
        got[0] = 8'h00; got[1] = 8'h00;
        while (frames < 2 && n < 500) begin
            if (!prev_sclk && ifa.sclk) cap = {cap[6:0], ifa.sdi};
            prev_sclk = ifa.sclk;
            if (ifa.done) begin
                got[frames] = cap;
                frames++;
                if (frames == 1) ifa.wdata = 8'h80;
                else ifa.start = 1'b0;
            end
            if (ifa.csb && frames == 1) csb_hi++;
            @(negedge clk);
            n++;
        end
        ifa.start = 1'b0;
        check("b2b_frames", frames, 2);
        check("b2b_csb_gap", csb_hi, 1);
        check("b2b_byte0", got[0], 8'h01);
        check("b2b_byte1", got[1], 8'h80);
        check("b2b_stop", ifa.busy, 1'b0);
`ifdef SPI_TX_READBACK_EN
        rd_model = 8'h00;
        check("b2b_rdata", ifa.rdata, rd_model);
`endif

        // reset 30 cycles into a frame, then start together with rst
        ifa.start = 1'b1;
        ifa.wdata = 8'hC7;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (29) @(negedge clk);
        check("abort_pre_busy", ifa.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_idle_a("abort");
        ifa.start = 1'b1;
        @(negedge clk);
        check("rst_start_busy", ifa.busy, 1'b0);
        rst = 1'b0;
        ifa.start = 1'b0;
        rd_model = 8'h00;
        dones = 0; busy_n = 0;
        repeat (100) begin
            @(negedge clk);
            if (ifa.done) dones++;
            if (ifa.busy) busy_n++;
        end
        check("abort_no_done", dones, 0);
        check("abort_no_busy", busy_n, 0);
        send_frame_a(8'h96, 8'h69, 68, 8'h96, -1);

        // minimum timing instance
        ifb.start = 1'b1;
        ifb.wdata = 8'hFF;
        @(negedge clk);
        ifb.start = 1'b0;
        ifb.wdata = 8'h00;
        busy_n = 0; rises = 0; ones = 0; dones = 0; prev_sclk = 1'b0; n = 0;
        while (ifb.busy && n < 200) begin
            busy_n++;
            if (ifb.done) dones++;
            check("fast_sclk_wave", ifb.sclk, exp_sclk(n, 1, 1));
            if (!prev_sclk && ifb.sclk) begin
                rises++;
                if (ifb.sdi) ones++;
            end
            prev_sclk = ifb.sclk;
            @(negedge clk);
            n++;
        end
        check("fast_busy_cycles", busy_n, 18);
        check("fast_rises", rises, 8);
        check("fast_sdi_ones", ones, 8);
        check("fast_done_in_frame", dones, 0);
        check("fast_done", ifb.done, 1'b1);
        check("fast_csb_idle", ifb.csb, 1'b1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_tx_8b.md
SPI_TX_8B -- requirements
Module: spi_tx_8b

Interface
REQ-001 Parameter CLK_DIV, default 4, SHALL set the sclk half-period in clk cycles; legal range 1..255.
REQ-002 Parameter CSB_SETUP, default 2, SHALL set the clk cycles from csb falling to the first sclk low half; legal range 1..15.
REQ-003 Parameter CSB_HOLD, default 2, SHALL set the clk cycles from the last sclk falling to csb rising; legal range 1..15.
REQ-004 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  request to send one frame; one-cycle pulse or level.
REQ-007 wdata  input  8  frame data, MSB first.
REQ-008 busy  output  1  high while a frame is in progress.
REQ-009 done  output  1  one-cycle pulse at frame end.
REQ-010 sclk  output  1  SPI clock, idles low.
REQ-011 sdi  output  1  serial data to the spi_write_8b receiver.
REQ-012 csb  output  1  active-low chip select, idles high.

Function
REQ-013 States SHALL be IDLE, SETUP, SHIFT and HOLD.
REQ-014 In IDLE with start=1, the block SHALL latch wdata and enter SETUP; from the next cycle csb=0, busy=1 and sdi=wdata[7].
REQ-015 SETUP SHALL last CSB_SETUP cycles with sclk=0, then go to SHIFT.
REQ-016 Each bit in SHIFT SHALL be CLK_DIV cycles sclk=0 followed by CLK_DIV cycles sclk=1.
REQ-017 sdi SHALL change only at the end of a high half (the sclk falling edge) and SHALL be stable through each sclk rising edge.
REQ-018 After 8 bits (16*CLK_DIV cycles) the block SHALL enter HOLD with sclk=0 for CSB_HOLD cycles.
REQ-019 Leaving HOLD, the block SHALL enter IDLE; in that same first IDLE cycle csb=1, busy=0, done=1.
REQ-020 busy SHALL be high for exactly CSB_SETUP+16*CLK_DIV+CSB_HOLD cycles per frame.
REQ-021 start while busy=1 SHALL be ignored and SHALL not be queued.
REQ-022 start in the cycle done=1 SHALL be accepted, giving back-to-back frames with csb high for exactly one cycle between them.
REQ-023 The bit counter SHALL be 3 bits and SHALL wrap 7->0 only at the end of a frame; the divider counter SHALL be 8 bits.
REQ-024 wdata changes after acceptance SHALL not affect the frame in progress.
REQ-025 In IDLE, sdi SHALL be 0.

Reset
REQ-026 rst=1 SHALL, at the next edge and regardless of state, force IDLE, csb=1, sclk=0, sdi=0, busy=0, done=0, and clear all counters.
REQ-027 A frame aborted by rst SHALL not pulse done.
REQ-028 start asserted together with rst SHALL be ignored.

Configuration
REQ-029 Macro SPI_TX_READBACK_EN SHALL control readback.
- Defined: adds port sdo (input, 1 bit) and port rdata (output, 8 bits, reset 0x00). sdo SHALL be sampled in the clk cycle where sclk goes 0->1 and shifted in MSB first. rdata SHALL update in the done cycle and hold until the next done.
- Undefined: neither port exists; the remaining behaviour SHALL be identical.

Structure
REQ-030 Package spi_tx_pkg SHALL hold the state enum, the bit-count width (3) and the divider width (8).
REQ-031 Sub-module spi_clk_div SHALL generate the half-period tick from CLK_DIV; it is enabled only in SHIFT.

Verification
REQ-032 Defaults, wdata=0xA5 -> exactly 8 sclk rising edges; sdi at those edges reads 1,0,1,0,0,1,0,1; busy high 68 cycles; one done pulse.
REQ-033 start re-pulsed 10 cycles into a frame -> no effect; exactly one frame and one done.
REQ-034 rst asserted 30 cycles into a frame -> next cycle csb=1, sclk=0, busy=0; no done pulse.
REQ-035 start held high, wdata=0x01 then 0x80 -> two frames with csb high exactly 1 cycle between them; the receiver captures 0x01 then 0x80.
REQ-036 CLK_DIV=1, CSB_SETUP=1, CSB_HOLD=1, wdata=0xFF -> busy high 18 cycles; sdi=1 at all 8 rising edges.
REQ-037 SPI_TX_READBACK_EN defined, sdo driven with pattern 0x3C -> rdata=0x3C in the done cycle.
